// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - ASCII to Morse on/off keying encoder with valid/ready intake
module morse_encoder #(
  parameter int UNIT_CLKS = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  output logic       key_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int CW = $clog2(4 * UNIT_CLKS + 1);
  localparam logic [CW-1:0] DUR_1 = CW'(UNIT_CLKS);
  localparam logic [CW-1:0] DUR_3 = CW'(3 * UNIT_CLKS);
  localparam logic [CW-1:0] DUR_4 = CW'(4 * UNIT_CLKS);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MARK,
    S_ELEM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      char_q, char_d;
  logic            key_q, key_d;

  // Table entry {len, pat}; pat[0] is sent first, 1 = dash. len 0 = unsupported.
  function automatic logic [7:0] morse_lookup(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] e;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h41: e = {3'd2, 5'b00010}; // A .-
      8'h42: e = {3'd4, 5'b00001}; // B -...
      8'h43: e = {3'd4, 5'b00101}; // C -.-.
      8'h44: e = {3'd3, 5'b00001}; // D -..
      8'h45: e = {3'd1, 5'b00000}; // E .
      8'h46: e = {3'd4, 5'b00100}; // F ..-.
      8'h47: e = {3'd3, 5'b00011}; // G --.
      8'h48: e = {3'd4, 5'b00000}; // H ....
      8'h49: e = {3'd2, 5'b00000}; // I ..
      8'h4A: e = {3'd4, 5'b01110}; // J .---
      8'h4B: e = {3'd3, 5'b00101}; // K -.-
      8'h4C: e = {3'd4, 5'b00010}; // L .-..
      8'h4D: e = {3'd2, 5'b00011}; // M --
      8'h4E: e = {3'd2, 5'b00001}; // N -.
      8'h4F: e = {3'd3, 5'b00111}; // O ---
      8'h50: e = {3'd4, 5'b00110}; // P .--.
      8'h51: e = {3'd4, 5'b01011}; // Q --.-
      8'h52: e = {3'd3, 5'b00010}; // R .-.
      8'h53: e = {3'd3, 5'b00000}; // S ...
      8'h54: e = {3'd1, 5'b00001}; // T -
      8'h55: e = {3'd3, 5'b00100}; // U ..-
      8'h56: e = {3'd4, 5'b01000}; // V ...-
      8'h57: e = {3'd3, 5'b00110}; // W .--
      8'h58: e = {3'd4, 5'b01001}; // X -..-
      8'h59: e = {3'd4, 5'b01101}; // Y -.--
      8'h5A: e = {3'd4, 5'b00011}; // Z --..
      8'h30: e = {3'd5, 5'b11111}; // 0 -----
      8'h31: e = {3'd5, 5'b11110}; // 1 .----
      8'h32: e = {3'd5, 5'b11100}; // 2 ..---
      8'h33: e = {3'd5, 5'b11000}; // 3 ...--
      8'h34: e = {3'd5, 5'b10000}; // 4 ....-
      8'h35: e = {3'd5, 5'b00000}; // 5 .....
      8'h36: e = {3'd5, 5'b00001}; // 6 -....
      8'h37: e = {3'd5, 5'b00011}; // 7 --...
      8'h38: e = {3'd5, 5'b00111}; // 8 ---..
      8'h39: e = {3'd5, 5'b01111}; // 9 ----.
      default: e = 8'h00;
    endcase
    return e;
  endfunction

  logic [7:0]    entry;
  logic [2:0]    len;
  logic [4:0]    pat;
  logic          is_space;
  logic          last_elem;
  logic [CW-1:0] mark_dur;

  // Decode the latched character and the duration of the current element.
  always_comb begin
    entry     = morse_lookup(char_q);
    len       = entry[7:5];
    pat       = entry[4:0];
    is_space  = (char_q == 8'h20);
    last_elem = (idx_q == len - 3'd1);
    mark_dur  = pat[idx_q] ? DUR_3 : DUR_1;
  end

  // Next-state logic: counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    idx_d   = idx_q;
    char_d  = char_q;
    unique case (state_q)
      S_IDLE: begin
        if (char_valid_i) begin
          char_d  = char_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        idx_d = 3'd0;
        if (is_space)        state_d = S_WORD_GAP;
        else if (len == 3'd0) state_d = S_IDLE;
        else                 state_d = S_MARK;
      end
      S_MARK: begin
        if (cnt_q == mark_dur - ONE) state_d = last_elem ? S_CHAR_GAP : S_ELEM_GAP;
      end
      S_ELEM_GAP: begin
        if (cnt_q == DUR_1 - ONE) begin
          state_d = S_MARK;
          idx_d   = idx_q + 3'd1;
        end
      end
      S_CHAR_GAP: begin
        if (cnt_q == DUR_3 - ONE) state_d = S_IDLE;
      end
      S_WORD_GAP: begin
        if (cnt_q == DUR_4 - ONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    key_d = (state_d == S_MARK);
  end

  // State, counters and registered key output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      char_q  <= 8'h00;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      key_q   <= key_d;
    end
  end

  assign char_ready_o = (state_q == S_IDLE);
  assign busy_o       = ~char_ready_o;
  assign key_o        = key_q;
  assign err_o        = (state_q == S_LOOKUP) && !is_space && (len == 3'd0);

endmodule
